// File: rtl/stream_pack_writer.sv
// Byte-stream to 32-bit word packer writing into a wrapping memory region.
// Define STREAM_PACK_FLUSH_EN to write a partial final word instead of dropping it.
module stream_pack_writer #(
  parameter int unsigned DEPTH     = 64000,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned BASE_WORD = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        snk_data,
  input  logic              snk_valid,
  input  logic              snk_eop,
  output logic              snk_ready,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] words_written,
  output logic              wrapped
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_WORD);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(BASE_WORD + DEPTH - 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        lane_q;
  logic [31:0]       data_q;
  logic [3:0]        be_q;
  logic              eop_q;
  logic [ADDR_W-1:0] ww_q;
  logic              wrap_q;

  logic accept;
  logic drop;

  assign accept = (state == S_FILL) && snk_valid;

  // A short final word is either flushed or thrown away at eop
`ifdef STREAM_PACK_FLUSH_EN
  assign drop = 1'b0;
`else
  assign drop = accept && snk_eop && (lane_q != 2'd3);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      addr_q <= BASE_A;
      lane_q <= '0;
      data_q <= '0;
      be_q   <= '0;
      eop_q  <= 1'b0;
      ww_q   <= '0;
      wrap_q <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_FILL;
            addr_q <= BASE_A;
            lane_q <= '0;
            data_q <= '0;
            be_q   <= '0;
            eop_q  <= 1'b0;
            ww_q   <= '0;
            wrap_q <= 1'b0;
          end
        end
        S_FILL: begin
          if (drop) begin
            lane_q <= '0;
            data_q <= '0;
            be_q   <= '0;
            eop_q  <= 1'b0;
            state  <= S_DONE;
          end else if (accept) begin
            data_q[{lane_q, 3'b000} +: 8] <= snk_data;
            be_q   <= {be_q[2:0], 1'b1};
            lane_q <= lane_q + 2'd1;
            eop_q  <= snk_eop;
            if (snk_eop || lane_q == 2'd3)
              state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (!avm_waitrequest) begin
            if (addr_q == LAST_A) begin
              addr_q <= BASE_A;
              wrap_q <= 1'b1;
            end else begin
              addr_q <= addr_q + 1'b1;
            end
            ww_q   <= ww_q + 1'b1;
            lane_q <= '0;
            data_q <= '0;
            be_q   <= '0;
            state  <= eop_q ? S_DONE : S_FILL;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign snk_ready      = (state == S_FILL);
  assign avm_write      = (state == S_WRITE);
  assign avm_address    = addr_q;
  assign avm_writedata  = avm_write ? data_q : '0;
  assign avm_byteenable = avm_write ? be_q : '0;
  assign busy           = (state != S_IDLE);
  assign done           = (state == S_DONE);
  assign words_written  = ww_q;
  assign wrapped        = wrap_q;

endmodule

// File: doc/stream_pack_writer.md
STREAM_PACK_WRITER -- requirements
Module: stream_pack_writer

Interface
REQ-001 SHALL have parameter DEPTH, default 64000: word depth of the target memory region.
REQ-002 SHALL have parameter ADDR_W, default 16: word-address width.
REQ-003 SHALL have parameter BASE_WORD, default 0: first word address written.
REQ-004 SHALL have port clk  in  1: single clock; all logic on rising edge.
REQ-005 SHALL have port reset  in  1: reset, synchronous, active-high.
REQ-006 SHALL have port start  in  1: one-cycle pulse that arms a capture.
REQ-007 SHALL have port snk_data  in  8: stream byte.
REQ-008 SHALL have port snk_valid  in  1: byte valid.
REQ-009 SHALL have port snk_eop  in  1: last byte of the packet.
REQ-010 SHALL have port snk_ready  out  1: byte accepted when valid&ready.
REQ-011 SHALL have port avm_address  out  ADDR_W: word address to the memory.
REQ-012 SHALL have port avm_write  out  1: write strobe.
REQ-013 SHALL have port avm_writedata  out  32: packed word.
REQ-014 SHALL have port avm_byteenable  out  4: byte lanes written.
REQ-015 SHALL have port avm_waitrequest  in  1: memory stall.
REQ-016 SHALL have port busy  out  1: high in any state other than IDLE.
REQ-017 SHALL have port done  out  1: one-cycle pulse at packet completion.
REQ-018 SHALL have port words_written  out  ADDR_W: words committed since the last start.
REQ-019 SHALL have port wrapped  out  1: sticky flag, address wrapped since the last start.

Function
REQ-020 SHALL implement states IDLE, FILL, WRITE and DONE.
REQ-021 IDLE SHALL hold snk_ready=0, and on start SHALL go to FILL with address=BASE_WORD, lane=0, words_written=0 and wrapped=0.
REQ-022 start SHALL be ignored outside IDLE.
REQ-023 FILL SHALL hold snk_ready=1 and place each accepted byte in lane[lane]: lane 0 = bits 7:0, little-endian.
REQ-024 FILL SHALL go to WRITE on the cycle after the lane-3 byte is accepted, or after a byte with snk_eop=1 is accepted.
REQ-025 WRITE SHALL hold snk_ready=0 and avm_write=1, with address, data and byteenable stable while avm_waitrequest=1.
REQ-026 A write SHALL complete on the first WRITE cycle in which avm_waitrequest=0.
REQ-027 On write completion, address SHALL increment, words_written SHALL increment, and lanes SHALL clear to zero.
REQ-028 On write completion, the next state SHALL be DONE if eop was captured, else FILL.
REQ-029 Wrap: a completed write at BASE_WORD+DEPTH-1 SHALL set the next address to BASE_WORD and set wrapped=1.
REQ-030 avm_byteenable SHALL be 1111 for a full word; for a partial word it SHALL be 0001, 0011 or 0111 for 1, 2 or 3 filled lanes.
REQ-031 Unfilled lanes of avm_writedata SHALL be zero.
REQ-032 DONE SHALL assert done for exactly one cycle, then go to IDLE; words_written and wrapped SHALL hold until the next start.
REQ-033 avm_write SHALL be 0 in every state except WRITE.
REQ-034 Minimum throughput SHALL be 4 bytes per 5 cycles with avm_waitrequest=0.

Reset
REQ-035 reset SHALL force, on the next edge: state=IDLE, address=BASE_WORD, lanes=0, lane=0, and all outputs 0 (snk_ready, avm_write, avm_writedata, avm_byteenable, busy, done, words_written, wrapped).
REQ-036 reset mid-write SHALL drop avm_write on the next edge with no completion counted, and the partial word SHALL be discarded.
REQ-037 reset SHALL take priority over start.

Configuration
REQ-038 Macro STREAM_PACK_FLUSH_EN SHALL select how a partial final word is handled.
REQ-039 With STREAM_PACK_FLUSH_EN defined, an eop with fewer than 4 lanes filled SHALL write that partial word per REQ-030.
REQ-040 Without STREAM_PACK_FLUSH_EN, partial lanes at eop SHALL be discarded, with no write and no count, and the block SHALL go to DONE directly.
REQ-041 Without STREAM_PACK_FLUSH_EN, an eop on lane 3 SHALL still write the full word.

Verification
REQ-042 Full word: start; bytes 11,22,33,44 with eop on 44 -> one write at addr 0, data 44332211, be 1111, done pulse, words_written=1.
REQ-043 Partial flush (STREAM_PACK_FLUSH_EN defined): start; bytes AA,BB with eop on BB -> write data 0000BBAA, be 0011; with the macro undefined -> no write, done pulse, words_written=0.
REQ-044 Stall: waitrequest held high 3 cycles during a write -> avm_write stable for 4 cycles, snk_ready=0 throughout, exactly one write counted.
REQ-045 Wrap: DEPTH=4, 20 bytes -> writes to addresses 0,1,2,3,0; wrapped=1; words_written=5.
REQ-046 Reset mid-WRITE: reset asserted while waitrequest=1 -> next cycle avm_write=0, busy=0, words_written=0; a subsequent start behaves as after power-up.
